// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment glyph table and ghost-guard length.
// The optional PWM dimming feature is enabled by defining SEVEN_SEG_PWM_EN.
package seven_seg_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned GUARD_LEN = 16;

    // Active-high patterns, segment a at bit 0 through g at bit 6; entry 15 first.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] hex_pattern(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = hex_pattern(hex);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner with shadow/display double buffering and ghost guard.
// Define SEVEN_SEG_PWM_EN to gate digit enables by the brightness input.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned SCAN_BITS      = 18,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [SEG_W-1:0]      segs,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIG_W = 4 * DIGITS;

    logic [SCAN_BITS-1:0] scan_cnt, cnt_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [DIG_W-1:0]     sh_digits, sh_digits_nxt, disp_digits, disp_digits_nxt;
    logic [DIGITS-1:0]    sh_dp, sh_dp_nxt, disp_dp, disp_dp_nxt;
    logic [DIGITS-1:0]    sh_blank, sh_blank_nxt, disp_blank, disp_blank_nxt;
    logic                 tick_c, wrap_c;

    logic [3:0]           nib_c;
    logic                 blank_c, dp_c;
    logic [DIGITS-1:0]    onehot_c, sel_c;
    logic [SEG_W-1:0]     pattern_c, seg_raw_c;
    logic                 guard_ok_c, pwm_ok_c, lit_c;
    logic [SEG_W-1:0]     segs_nxt;
    logic                 dp_nxt;
    logic [DIGITS-1:0]    digit_sel_nxt;

    // Scan timing and buffer next state; display only swaps at the frame wrap.
    always_comb begin
        cnt_nxt         = scan_cnt + SCAN_BITS'(1);
        tick_c          = &scan_cnt;
        wrap_c          = tick_c && (idx == IDX_W'(DIGITS - 1));
        idx_nxt         = idx;
        if (wrap_c)
            idx_nxt = '0;
        else if (tick_c)
            idx_nxt = idx + IDX_W'(1);
        sh_digits_nxt   = load ? digits_i : sh_digits;
        sh_dp_nxt       = load ? dp_i     : sh_dp;
        sh_blank_nxt    = load ? blank_i  : sh_blank;
        disp_digits_nxt = wrap_c ? sh_digits_nxt : disp_digits;
        disp_dp_nxt     = wrap_c ? sh_dp_nxt     : disp_dp;
        disp_blank_nxt  = wrap_c ? sh_blank_nxt  : disp_blank;
    end

    // Outputs are built from next state so they line up with the registered index.
    always_comb begin
        nib_c    = '0;
        blank_c  = 1'b1;
        dp_c     = 1'b0;
        onehot_c = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                nib_c       = disp_digits_nxt[4*k +: 4];
                blank_c     = disp_blank_nxt[k];
                dp_c        = disp_dp_nxt[k];
                onehot_c[k] = 1'b1;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex   (nib_c),
        .seg_c (pattern_c)
    );

`ifdef SEVEN_SEG_PWM_EN
    assign pwm_ok_c = cnt_nxt[SCAN_BITS-1 -: 4] < brightness;
`else
    logic pwm_unused;
    assign pwm_unused = ^brightness;
    assign pwm_ok_c   = 1'b1;
`endif

    always_comb begin
        guard_ok_c    = cnt_nxt >= SCAN_BITS'(GUARD_LEN);
        lit_c         = guard_ok_c && pwm_ok_c && !blank_c;
        sel_c         = lit_c ? onehot_c : '0;
        digit_sel_nxt = DIG_ACTIVE_LOW ? ~sel_c : sel_c;
        seg_raw_c     = blank_c ? '0 : pattern_c;
        segs_nxt      = SEG_ACTIVE_LOW ? ~seg_raw_c : seg_raw_c;
        dp_nxt        = SEG_ACTIVE_LOW ^ (dp_c && !blank_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            idx         <= '0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= '1;
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_blank  <= '1;
            segs        <= {SEG_W{SEG_ACTIVE_LOW}};
            dp          <= SEG_ACTIVE_LOW;
            digit_sel   <= {DIGITS{DIG_ACTIVE_LOW}};
            frame_done  <= 1'b0;
        end else begin
            scan_cnt    <= cnt_nxt;
            idx         <= idx_nxt;
            sh_digits   <= sh_digits_nxt;
            sh_dp       <= sh_dp_nxt;
            sh_blank    <= sh_blank_nxt;
            disp_digits <= disp_digits_nxt;
            disp_dp     <= disp_dp_nxt;
            disp_blank  <= disp_blank_nxt;
            segs        <= segs_nxt;
            dp          <= dp_nxt;
            digit_sel   <= digit_sel_nxt;
            frame_done  <= wrap_c;
        end
    end

endmodule
